lcd_scheduler: RTL and testbench

LCD_SCHEDULER -- requirements
Module: lcd_scheduler

---
 rtl/lcd_pkg.sv | 17 +
 rtl/lcd_strobe.sv | 72 +++++++
 rtl/lcd_scheduler.sv | 146 ++++++++++++++
 tb/tb_lcd_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - LCD command codes and scheduler state type
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h30;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_HOME     = 8'h02;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE
  } lcd_state_e;

endpackage

// File: rtl/lcd_strobe.sv
// rtl/lcd_strobe.sv - en timing for one LCD transfer: EN_HALF cycles low, EN_HALF high
// quiet keeps en low for the whole transfer (used for settle gaps).
module lcd_strobe #(
  parameter int unsigned EN_HALF = 131070
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic quiet,
  output logic en,
  output logic half_done,
  output logic done
);

  localparam int unsigned CW = $clog2(EN_HALF + 1);
  localparam logic [CW-1:0] RELOAD = CW'(EN_HALF);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          phase_q, phase_d;
  logic          en_q, en_d;
  logic          quiet_q, quiet_d;
  logic          last;

  always_comb begin
    last      = busy_q && (cnt_q == CW'(1));
    half_done = last && !phase_q;
    done      = last && phase_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    phase_d   = phase_q;
    en_d      = en_q;
    quiet_d   = quiet_q;
    if (busy_q && (cnt_q != '0)) cnt_d = cnt_q - CW'(1);
    if (half_done) begin
      cnt_d   = RELOAD;
      phase_d = 1'b1;
      en_d    = !quiet_q;
    end
    if (done) begin
      busy_d  = 1'b0;
      phase_d = 1'b0;
      en_d    = 1'b0;
    end
    // A start on the done cycle chains the next transfer with no gap.
    if (start) begin
      busy_d  = 1'b1;
      phase_d = 1'b0;
      cnt_d   = RELOAD;
      quiet_d = quiet;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      phase_q <= 1'b0;
      en_q    <= 1'b0;
      quiet_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      phase_q <= phase_d;
      en_q    <= en_d;
      quiet_q <= quiet_d;
    end
  end

  assign en = en_q;

endmodule

// File: rtl/lcd_scheduler.sv
// rtl/lcd_scheduler.sv - two-requester round-robin LCD write scheduler with init sequence
// LCD_SCHEDULER_CLEAR_EN adds a clear command and CLEAR_WAIT quiet transfers to init.
module lcd_scheduler #(
  parameter int unsigned EN_HALF    = 131070,
  parameter int unsigned CLEAR_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_rs,
  input  logic [15:0] req_data,
  output logic [1:0]  req_ready,
  output logic        rs,
  output logic        rw,
  output logic        en,
  output logic [7:0]  dat,
  output logic        init_done
);
  import lcd_pkg::*;

`ifdef LCD_SCHEDULER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif
  localparam int unsigned QUIET = CLEAR_EN ? CLEAR_WAIT : 32'd0;
  localparam int unsigned QW = (QUIET > 1) ? $clog2(QUIET + 1) : 1;
  localparam logic [QW-1:0] QUIET_N = QW'(QUIET);
  localparam logic [2:0] LAST_IDX = CLEAR_EN ? 3'd4 : 3'd3;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = LCD_FUNC_SET;
      3'd1:    init_cmd = LCD_DISP_ON;
      3'd2:    init_cmd = LCD_ENTRY;
      3'd3:    init_cmd = CLEAR_EN ? LCD_CLEAR : LCD_HOME;
      default: init_cmd = LCD_HOME;
    endcase
  endfunction

  lcd_state_e    state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          rs_q, rs_d;
  logic [7:0]    dat_q, dat_d;
  logic [2:0]    idx_q, idx_d;
  logic [QW-1:0] quiet_cnt_q, quiet_cnt_d;
  logic          init_done_q, init_done_d;
  logic [1:0]    ready;
  logic          start, quiet_start, sel, half_done, done;

  lcd_strobe #(.EN_HALF(EN_HALF)) u_strobe (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .quiet     (quiet_start),
    .en        (en),
    .half_done (half_done),
    .done      (done)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rs_d        = rs_q;
    dat_d       = dat_q;
    idx_d       = idx_q;
    quiet_cnt_d = quiet_cnt_q;
    init_done_d = init_done_q;
    ready       = 2'b00;
    start       = 1'b0;
    quiet_start = 1'b0;
    sel         = 1'b0;
    case (state_q)
      ST_INIT: begin
        dat_d   = init_cmd(3'd0);
        rs_d    = 1'b0;
        idx_d   = 3'd0;
        start   = 1'b1;
        state_d = ST_SETUP;
      end
      ST_IDLE: begin
        if (|req_valid) begin
          sel     = (&req_valid) ? ptr_q : req_valid[1];
          ready   = sel ? 2'b10 : 2'b01;
          rs_d    = req_rs[sel];
          dat_d   = sel ? req_data[15:8] : req_data[7:0];
          ptr_d   = ~sel;
          start   = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (half_done) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (done) begin
          state_d = ST_IDLE;
          if (!init_done_q) begin
            // After the clear command, idle transfers with en held low let the panel settle.
            if ((dat_q == LCD_CLEAR) && (quiet_cnt_q != QUIET_N)) begin
              quiet_cnt_d = quiet_cnt_q + QW'(1);
              start       = 1'b1;
              quiet_start = 1'b1;
              state_d     = ST_SETUP;
            end else if (idx_q == LAST_IDX) begin
              init_done_d = 1'b1;
            end else begin
              idx_d   = idx_q + 3'd1;
              dat_d   = init_cmd(idx_q + 3'd1);
              start   = 1'b1;
              state_d = ST_SETUP;
            end
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      ptr_q       <= 1'b0;
      rs_q        <= 1'b0;
      dat_q       <= 8'h00;
      idx_q       <= 3'd0;
      quiet_cnt_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rs_q        <= rs_d;
      dat_q       <= dat_d;
      idx_q       <= idx_d;
      quiet_cnt_q <= quiet_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign req_ready = ready;
  assign rs        = rs_q;
  assign rw        = 1'b0;
  assign dat       = dat_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_scheduler.sv
// tb/tb_lcd_scheduler.sv - randomized bench for lcd_scheduler against a transfer-level model
`timescale 1ns/1ps
module tb_lcd_scheduler;

  localparam int EH = 2;
  localparam int CWT = 1;
`ifdef LCD_SCHEDULER_CLEAR_EN
  localparam int N_INIT = 5;
  localparam int INIT_SPAN = 24;
  logic [7:0] init_seq [N_INIT] = '{8'h30, 8'h0C, 8'h06, 8'h01, 8'h02};
`else
  localparam int N_INIT = 4;
  localparam int INIT_SPAN = 16;
  logic [7:0] init_seq [N_INIT] = '{8'h30, 8'h0C, 8'h06, 8'h02};
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_rs = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  req_ready;
  logic        rs, rw, en, init_done;
  logic [7:0]  dat;

  lcd_scheduler #(.EN_HALF(EH), .CLEAR_WAIT(CWT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rs    (req_rs),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rs        (rs),
    .rw        (rw),
    .en        (en),
    .dat       (dat),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    logic       rs;
    int         rise;
    int         len;
  } xfer_t;

  xfer_t act_q[$];
  xfer_t exp_q[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    stable_err = 0;
  int    m_free;
  logic  m_ptr;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observed transfers: one entry per en pulse, with rise cycle and high length.
  initial begin
    logic en_prev;
    en_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) en_prev = 1'b0;
      else begin
        if (en && !en_prev) act_q.push_back('{dat, rs, cyc, 0});
        if (en && act_q.size() > 0) begin
          if (act_q[act_q.size()-1].dat !== dat || act_q[act_q.size()-1].rs !== rs) stable_err++;
          act_q[act_q.size()-1].len++;
        end
        en_prev = en;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  function automatic logic [72:0] pk(input xfer_t x);
    return {x.dat, x.rs, x.rise, x.len};
  endfunction

  // A grant is possible once the previous transfer plus one idle cycle has elapsed.
  task automatic model_step(output logic [1:0] exp);
    logic w;
    exp = 2'b00;
    if (cyc >= m_free && req_valid != 2'b00) begin
      if (req_valid == 2'b11) w = m_ptr;
      else w = (req_valid == 2'b10);
      m_ptr  = !w;
      m_free = cyc + 2 * EH + 1;
      exp_q.push_back('{w ? req_data[15:8] : req_data[7:0], req_rs[w], cyc + EH + 1, EH});
      exp = w ? 2'b10 : 2'b01;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && act_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (2 * EH + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    n_tests++; if (en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b required 0", en); end
    n_tests++; if (dat !== 8'h00) begin n_fail++; $display("FAIL reset_dat: got %h required 00", dat); end
    n_tests++; if ({rs, rw} !== 2'b00) begin n_fail++; $display("FAIL reset_rs_rw: got %b required 00", {rs, rw}); end
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b required 00", req_ready); end
    n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b required 0", init_done); end
  endtask

  task automatic test_init(input bit pend);
    logic [1:0] exp;
    bit seen;
    int t0;
    act_q.delete();
    exp_q.delete();
    m_ptr = 1'b0;
    m_free = 1 << 30;
    req_valid = pend ? 2'b10 : 2'b00;
    req_rs = 2'b10;
    req_data = 16'h5A00;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) seen = 1;
      else begin
        n_tests++;
        if (req_ready !== 2'b00) begin n_fail++; $display("FAIL init_ready_hold: got %b required 00", req_ready); end
      end
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL init_done_timeout: init_done=%b required 1", init_done); end
    t0 = cyc;
    m_free = cyc;
    model_step(exp);
    n_tests++; if (req_ready !== exp) begin n_fail++; $display("FAIL init_first_idle_grant: got %b required %b", req_ready, exp); end
    @(posedge clk); #1 req_valid = 2'b00;
    n_tests++; if (act_q.size() != N_INIT) begin n_fail++; $display("FAIL init_count: got %0d required %0d", act_q.size(), N_INIT); end
    for (int i = 0; i < N_INIT && i < act_q.size(); i++) begin
      n_tests++;
      if (act_q[i].dat !== init_seq[i] || act_q[i].rs !== 1'b0 || act_q[i].len != EH) begin
        n_fail++;
        $display("FAIL init_cmd[%0d]: got dat=%h rs=%b len=%0d required dat=%h rs=0 len=%0d",
                 i, act_q[i].dat, act_q[i].rs, act_q[i].len, init_seq[i], EH);
      end
    end
    if (act_q.size() > 0) begin
      n_tests++;
      if (t0 - (act_q[0].rise - EH) != INIT_SPAN) begin
        n_fail++; $display("FAIL init_done_time: got %0d required %0d", t0 - (act_q[0].rise - EH), INIT_SPAN);
      end
    end
`ifdef LCD_SCHEDULER_CLEAR_EN
    if (act_q.size() == 5) begin
      n_tests++;
      if (act_q[4].rise - act_q[3].rise != 2 * EH + 2 * EH * CWT) begin
        n_fail++; $display("FAIL clear_gap: got %0d required %0d", act_q[4].rise - act_q[3].rise, 2 * EH + 2 * EH * CWT);
      end
    end
`endif
    repeat (N_INIT) if (act_q.size() > 0) void'(act_q.pop_front());
  endtask

  task automatic test_same_cycle();
    logic [1:0] exp, rdy;
    int order[$];
    @(posedge clk); #1;
    req_valid = 2'b11; req_rs = 2'b11; req_data = 16'h4241;
    for (int i = 0; i < 40 && req_valid != 2'b00; i++) begin
      @(negedge clk);
      rdy = req_ready;
      model_step(exp);
      n_tests++; if (rdy !== exp) begin n_fail++; $display("FAIL same_cycle_ready: got %b required %b", rdy, exp); end
      if (rdy[0]) order.push_back(0);
      if (rdy[1]) order.push_back(1);
      @(posedge clk); #1 req_valid = req_valid & ~rdy;
    end
    req_valid = 2'b00;
    n_tests++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
      n_fail++; $display("FAIL same_cycle_order: got %0d grants first=%0d required 2 grants 0 then 1", order.size(), order[0]);
    end
    drain();
    n_tests++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL same_cycle_count: got %0d required %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_tests++;
      if (pk(act_q[i]) !== pk(exp_q[i])) begin n_fail++; $display("FAIL same_cycle_xfer[%0d]: got %h required %h", i, pk(act_q[i]), pk(exp_q[i])); end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp, rdy;
    int gc[$];
    int gw[$];
    @(posedge clk); #1;
    req_valid = 2'b11; req_rs = 2'($urandom); req_data = 16'($urandom);
    for (int i = 0; i < 100 && gc.size() < 4; i++) begin
      @(negedge clk);
      rdy = req_ready;
      model_step(exp);
      n_tests++; if (rdy !== exp) begin n_fail++; $display("FAIL b2b_ready: got %b required %b", rdy, exp); end
      if (rdy != 2'b00) begin gc.push_back(cyc); gw.push_back(int'(rdy[1])); end
      @(posedge clk); #1;
      if (rdy[0]) begin req_data[7:0] = 8'($urandom); req_rs[0] = 1'($urandom); end
      if (rdy[1]) begin req_data[15:8] = 8'($urandom); req_rs[1] = 1'($urandom); end
    end
    req_valid = 2'b00;
    n_tests++; if (gc.size() != 4) begin n_fail++; $display("FAIL b2b_grants: got %0d required 4", gc.size()); end
    for (int i = 0; i < gw.size(); i++) begin
      n_tests++; if (gw[i] != i % 2) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0d required %0d", i, gw[i], i % 2); end
      if (i > 0) begin
        n_tests++;
        if (gc[i] - gc[i-1] != 2 * EH + 1) begin n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d required %0d", i, gc[i] - gc[i-1], 2 * EH + 1); end
      end
    end
    drain();
    n_tests++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d required %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_tests++;
      if (pk(act_q[i]) !== pk(exp_q[i])) begin n_fail++; $display("FAIL b2b_xfer[%0d]: got %h required %h", i, pk(act_q[i]), pk(exp_q[i])); end
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [1:0] exp, rdy;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = req_ready;
      model_step(exp);
      n_tests++; if (rdy !== exp) begin n_fail++; $display("FAIL random_ready: cycle %0d got %b required %b", cyc, rdy, exp); end
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (rdy[r] || !req_valid[r]) begin
          if ($urandom_range(2) == 0) begin
            req_valid[r] = 1'b1;
            req_rs[r] = 1'($urandom);
            req_data[r*8 +: 8] = 8'($urandom);
          end else req_valid[r] = 1'b0;
        end else if ($urandom_range(9) == 0) req_valid[r] = 1'b0;
      end
    end
    req_valid = 2'b00;
    drain();
    n_tests++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count: got %0d required %0d", act_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_tests++;
      if (pk(act_q[i]) !== pk(exp_q[i])) begin n_fail++; $display("FAIL random_xfer[%0d]: got %h required %h", i, pk(act_q[i]), pk(exp_q[i])); end
    end
    n_tests++; if (stable_err != 0) begin n_fail++; $display("FAIL bus_stable: got %0d changes while en high required 0", stable_err); end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit hit;
    @(posedge clk); #1;
    req_valid = 2'b01; req_rs = 2'b01; req_data = 16'h00C3;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (en === 1'b1) hit = 1;
    end
    n_tests++; if (!hit) begin n_fail++; $display("FAIL mid_reset_strobe: en never high, required 1"); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (en !== 1'b0) begin n_fail++; $display("FAIL mid_reset_en: got %b required 0", en); end
    n_tests++; if (dat !== 8'h00) begin n_fail++; $display("FAIL mid_reset_dat: got %h required 00", dat); end
    n_tests++; if ({rs, req_ready, init_done} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_reset_ctrl: got rs/ready/init_done=%b required 0000", {rs, req_ready, init_done});
    end
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    test_init(1'b0);
  endtask

  initial begin
    test_reset();
    test_init(1'b1);
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
